// File: rtl/cpu7_dmw_tlb_if.sv
// Translation request/response bundle between the cache (master) and the
// DMW TLB (slave), carried over the existing req/finish handshake.
interface cpu7_dmw_tlb_if #(
  parameter int GRLEN  = 32,
  parameter int PABITS = 32
);
  logic              tlb_req;
  logic [GRLEN-1:0]  tlb_vaddr;
  logic              tlb_cancel;
  logic              tlb_busy;
  logic              tlb_finish;
  logic              tlb_hit;
  logic [PABITS-1:0] tlb_paddr;
  logic              tlb_uncache;
  logic [5:0]        tlb_exccode;

  modport master (
    output tlb_req, tlb_vaddr, tlb_cancel,
    input  tlb_busy, tlb_finish, tlb_hit, tlb_paddr, tlb_uncache, tlb_exccode
  );

  modport slave (
    input  tlb_req, tlb_vaddr, tlb_cancel,
    output tlb_busy, tlb_finish, tlb_hit, tlb_paddr, tlb_uncache, tlb_exccode
  );
endinterface

// File: rtl/cpu7_dmw_tlb.sv
// cpu7 translation unit: owns CRMD/DMW0/DMW1 and translates one port in
// direct-address mode or through two direct-mapped windows.
module cpu7_dmw_tlb #(
  parameter int GRLEN   = 32,
  parameter int PABITS  = 32,
  parameter int CSR_BIT = 14,
  parameter int IS_DATA = 0,
  parameter int LATENCY = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               csr_wen,
  input  logic [CSR_BIT-1:0] csr_waddr,
  input  logic [GRLEN-1:0]   csr_wdata,
  cpu7_dmw_tlb_if.slave      tlb,
  output logic [GRLEN-1:0]   crmd_q
);

  localparam logic [CSR_BIT-1:0] ADDR_CRMD = CSR_BIT'(12'h000);
  localparam logic [CSR_BIT-1:0] ADDR_DMW0 = CSR_BIT'(12'h180);
  localparam logic [CSR_BIT-1:0] ADDR_DMW1 = CSR_BIT'(12'h181);
  localparam logic [GRLEN-1:0]   CRMD_MASK = GRLEN'(32'h0000_01FF);
  localparam logic [GRLEN-1:0]   DMW_MASK  = GRLEN'(32'hEE00_0039);
  localparam logic [GRLEN-1:0]   CRMD_RST  = GRLEN'(32'h0000_0008);
  localparam logic [1:0]         CNT_INIT  = 2'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [1:0]         cnt_r;
  logic               accept_s, load_s, finish_s;
  logic [GRLEN-1:0]   crmd_r, dmw0_r, dmw1_r;
  logic [1:0]         da_mat_s;
  logic               hit_s, uncache_s;
  logic [PABITS-1:0]  paddr_s;
  logic [5:0]         exccode_s;
  logic               pend_hit_r, pend_uncache_r;
  logic [PABITS-1:0]  pend_paddr_r;
  logic [5:0]         pend_exccode_r;
  logic               hit_r, uncache_r;
  logic [PABITS-1:0]  paddr_r;
  logic [5:0]         exccode_r;
  logic               unused_s;

  // PLV 1 and 2 never match a window; 0 and 3 each have their own enable.
  function automatic logic dmw_match(input logic en_plv0, input logic en_plv3,
                                     input logic [2:0] vseg, input logic [1:0] plv,
                                     input logic [2:0] va_seg);
    logic plv_ok;
    case (plv)
      2'd0:    plv_ok = en_plv0;
      2'd3:    plv_ok = en_plv3;
      default: plv_ok = 1'b0;
    endcase
    return plv_ok && (vseg == va_seg);
  endfunction

  function automatic logic [PABITS-1:0] dmw_paddr(input logic [2:0] pseg,
                                                  input logic [28:0] va_low);
    logic [31:0] pa;
    pa = {pseg, va_low};
    return pa[PABITS-1:0];
  endfunction

  assign unused_s = ^{dmw0_r, dmw1_r};

  // Translation of the incoming address against the pre-write CSR contents.
  always_comb begin
    hit_s     = 1'b0;
    paddr_s   = {PABITS{1'b0}};
    uncache_s = 1'b0;
    exccode_s = 6'h3F;
    da_mat_s  = (IS_DATA != 0) ? crmd_r[8:7] : crmd_r[6:5];
    if (crmd_r[3]) begin
      hit_s     = 1'b1;
      paddr_s   = tlb.tlb_vaddr[PABITS-1:0];
      uncache_s = (da_mat_s == 2'd0);
      exccode_s = 6'h00;
    end else if (crmd_r[4] && dmw_match(dmw0_r[0], dmw0_r[3], dmw0_r[31:29],
                                        crmd_r[1:0], tlb.tlb_vaddr[31:29])) begin
      hit_s     = 1'b1;
      paddr_s   = dmw_paddr(dmw0_r[27:25], tlb.tlb_vaddr[28:0]);
      uncache_s = (dmw0_r[5:4] == 2'd0);
      exccode_s = 6'h00;
    end else if (crmd_r[4] && dmw_match(dmw1_r[0], dmw1_r[3], dmw1_r[31:29],
                                        crmd_r[1:0], tlb.tlb_vaddr[31:29])) begin
      hit_s     = 1'b1;
      paddr_s   = dmw_paddr(dmw1_r[27:25], tlb.tlb_vaddr[28:0]);
      uncache_s = (dmw1_r[5:4] == 2'd0);
      exccode_s = 6'h00;
    end else begin
      hit_s     = 1'b0;
      paddr_s   = {PABITS{1'b0}};
      uncache_s = 1'b0;
      exccode_s = 6'h3F;
    end
  end

  // Request FSM next state; outputs are refreshed on the edge entering RESP.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    load_s      = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tlb.tlb_req) begin
          accept_s = 1'b1;
          if (LATENCY > 1) begin
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_RESP;
            load_s      = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (tlb.tlb_cancel) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == 2'd1) begin
          state_nxt_s = ST_RESP;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        finish_s    = !tlb.tlb_cancel;
        state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and latency countdown.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        cnt_r <= CNT_INIT;
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r - 2'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Result captured at accept, published to the cache on entry to RESP.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend_hit_r     <= 1'b0;
      pend_paddr_r   <= {PABITS{1'b0}};
      pend_uncache_r <= 1'b0;
      pend_exccode_r <= 6'h00;
      hit_r          <= 1'b0;
      paddr_r        <= {PABITS{1'b0}};
      uncache_r      <= 1'b0;
      exccode_r      <= 6'h00;
    end else begin
      if (accept_s) begin
        pend_hit_r     <= hit_s;
        pend_paddr_r   <= paddr_s;
        pend_uncache_r <= uncache_s;
        pend_exccode_r <= exccode_s;
      end
      if (load_s) begin
        hit_r     <= accept_s ? hit_s     : pend_hit_r;
        paddr_r   <= accept_s ? paddr_s   : pend_paddr_r;
        uncache_r <= accept_s ? uncache_s : pend_uncache_r;
        exccode_r <= accept_s ? exccode_s : pend_exccode_r;
      end
    end
  end

  // CSR write port; unimplemented bits are stored as zero.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      crmd_r <= CRMD_RST;
      dmw0_r <= {GRLEN{1'b0}};
      dmw1_r <= {GRLEN{1'b0}};
    end else if (csr_wen) begin
      case (csr_waddr)
        ADDR_CRMD: crmd_r <= csr_wdata & CRMD_MASK;
        ADDR_DMW0: dmw0_r <= csr_wdata & DMW_MASK;
        ADDR_DMW1: dmw1_r <= csr_wdata & DMW_MASK;
        default:   crmd_r <= crmd_r;
      endcase
    end else begin
      crmd_r <= crmd_r;
    end
  end

  assign crmd_q          = crmd_r;
  assign tlb.tlb_busy    = (state_r != ST_IDLE);
  assign tlb.tlb_finish  = finish_s;
  assign tlb.tlb_hit     = hit_r;
  assign tlb.tlb_paddr   = paddr_r;
  assign tlb.tlb_uncache = uncache_r;
  assign tlb.tlb_exccode = exccode_r;

endmodule

// File: tb/tb_cpu7_dmw_tlb.sv
// Bench for cpu7_dmw_tlb: LATENCY=1 and LATENCY=3 instances share stimulus and
// are checked every cycle against a cycle-stamped translation model.
module tb_cpu7_dmw_tlb;

  typedef struct packed {
    logic        hit;
    logic [31:0] pa;
    logic        unc;
    logic [5:0]  exc;
  } res_t;

  logic        clk = 1'b0;
  logic        resetn, csr_wen, req, cancel;
  logic [13:0] csr_waddr;
  logic [31:0] csr_wdata, vaddr, crmd_q1, crmd_q3;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  bit   live[2];
  int   acc[2];
  int   lat[2] = '{1, 3};
  int   fin_cnt[2];
  res_t pend[2];
  res_t mout[2];
  logic [31:0] m_crmd, m_dmw0, m_dmw1;

  always #5 clk = ~clk;

  cpu7_dmw_tlb_if #(.GRLEN(32), .PABITS(32)) if1 ();
  cpu7_dmw_tlb_if #(.GRLEN(32), .PABITS(32)) if3 ();

  assign if1.tlb_req = req;  assign if1.tlb_vaddr = vaddr;  assign if1.tlb_cancel = cancel;
  assign if3.tlb_req = req;  assign if3.tlb_vaddr = vaddr;  assign if3.tlb_cancel = cancel;

  cpu7_dmw_tlb #(.GRLEN(32), .PABITS(32), .CSR_BIT(14), .IS_DATA(0), .LATENCY(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .csr_wen(csr_wen), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .tlb(if1), .crmd_q(crmd_q1));

  cpu7_dmw_tlb #(.GRLEN(32), .PABITS(32), .CSR_BIT(14), .IS_DATA(0), .LATENCY(3)) u_dut3 (
    .clk(clk), .resetn(resetn), .csr_wen(csr_wen), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .tlb(if3), .crmd_q(crmd_q3));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Translation rules: DA first, then windows (DMW0 written last so it wins).
  function automatic res_t xlate(input logic [31:0] crmd, input logic [31:0] d0,
                                 input logic [31:0] d1, input logic [31:0] va);
    res_t        r;
    logic [31:0] win[2];
    logic [1:0]  plv;
    win[0] = d0;
    win[1] = d1;
    plv    = crmd[1:0];
    r      = '{1'b0, 32'h0, 1'b0, 6'h3F};
    if (crmd[3]) begin
      r = '{1'b1, va, (crmd[6:5] == 2'd0), 6'h00};
    end else if (crmd[4]) begin
      for (int w = 1; w >= 0; w--) begin
        if (win[w][31:29] == va[31:29] &&
            ((plv == 2'd0 && win[w][0]) || (plv == 2'd3 && win[w][3])))
          r = '{1'b1, {win[w][27:25], va[28:0]}, (win[w][5:4] == 2'd0), 6'h00};
      end
    end
    return r;
  endfunction

  // Model update: accept/cancel/complete by cycle stamps, then CSR writes.
  always @(posedge clk) begin
    if (!resetn) begin
      chk_en = 1'b1;
      m_crmd = 32'h0000_0008;
      m_dmw0 = 32'h0;
      m_dmw1 = 32'h0;
      for (int i = 0; i < 2; i++) begin
        live[i] = 1'b0;
        mout[i] = '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit busy_now;
        busy_now = live[i] && cyc > acc[i] && cyc <= acc[i] + lat[i];
        if (busy_now && (cancel || cyc == acc[i] + lat[i])) begin
          live[i] = 1'b0;
        end else if (!busy_now && req) begin
          live[i] = 1'b1;
          acc[i]  = cyc;
          pend[i] = xlate(m_crmd, m_dmw0, m_dmw1, vaddr);
        end
      end
      if (csr_wen && csr_waddr == 14'h000) m_crmd = csr_wdata & 32'h0000_01FF;
      if (csr_wen && csr_waddr == 14'h180) m_dmw0 = csr_wdata & 32'hEE00_0039;
      if (csr_wen && csr_waddr == 14'h181) m_dmw1 = csr_wdata & 32'hEE00_0039;
    end
    cyc = cyc + 1;
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [1:0] busy_a, fin_a;
      res_t       act_a[2];
      busy_a   = {if3.tlb_busy, if1.tlb_busy};
      fin_a    = {if3.tlb_finish, if1.tlb_finish};
      act_a[0] = '{if1.tlb_hit, if1.tlb_paddr, if1.tlb_uncache, if1.tlb_exccode};
      act_a[1] = '{if3.tlb_hit, if3.tlb_paddr, if3.tlb_uncache, if3.tlb_exccode};
      for (int i = 0; i < 2; i++) begin
        bit be, fe;
        be = live[i] && cyc > acc[i] && cyc <= acc[i] + lat[i];
        fe = be && cyc == acc[i] + lat[i] && !cancel;
        if (live[i] && cyc == acc[i] + lat[i]) mout[i] = pend[i];
        check($sformatf("busy_lat%0d", lat[i]), 64'(busy_a[i]), 64'(be));
        check($sformatf("finish_lat%0d", lat[i]), 64'(fin_a[i]), 64'(fe));
        check($sformatf("result_lat%0d", lat[i]), 64'(act_a[i]), 64'(mout[i]));
        if (fin_a[i]) fin_cnt[i]++;
      end
      check("crmd_q_lat1", 64'(crmd_q1), 64'(m_crmd));
      check("crmd_q_lat3", 64'(crmd_q3), 64'(m_crmd));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic csr_wr(input logic [13:0] a, input logic [31:0] d);
    csr_wen = 1'b1; csr_waddr = a; csr_wdata = d;
    step();
    csr_wen = 1'b0;
  endtask

  task automatic request(input logic [31:0] va);
    req = 1'b1; vaddr = va;
    step();
    req = 1'b0;
    repeat (5) step();
  endtask

  task automatic expect_res(input string name, input logic hit, input logic [31:0] pa,
                            input logic unc, input logic [5:0] exc);
    check({name, "_lat1"}, {if1.tlb_hit, if1.tlb_paddr, if1.tlb_uncache, if1.tlb_exccode},
          {hit, pa, unc, exc});
    check({name, "_lat3"}, {if3.tlb_hit, if3.tlb_paddr, if3.tlb_uncache, if3.tlb_exccode},
          {hit, pa, unc, exc});
  endtask

  initial begin
    int f0;
    resetn = 1'b0; csr_wen = 1'b0; csr_waddr = 14'h0; csr_wdata = 32'h0;
    req = 1'b0; cancel = 1'b0; vaddr = 32'h0;
    fin_cnt[0] = 0; fin_cnt[1] = 0; acc[0] = -100; acc[1] = -100;
    step(); step();
    expect_res("reset_res", 1'b0, 32'h0, 1'b0, 6'h00);
    check("reset_busy", {if1.tlb_busy, if3.tlb_busy, if1.tlb_finish, if3.tlb_finish}, 4'h0);
    check("reset_crmd", crmd_q3, 32'h0000_0008);
    resetn = 1'b1;
    step();

    // DA mode straight out of reset; LATENCY=1 finishes the next cycle.
    req = 1'b1; vaddr = 32'h1C00_0040;
    step();
    check("da_finish_next", if1.tlb_finish, 1'b1);
    req = 1'b0;
    repeat (5) step();
    expect_res("da", 1'b1, 32'h1C00_0040, 1'b1, 6'h00);

    csr_wr(14'h000, 32'h0000_0010);
    csr_wr(14'h180, 32'hA000_0011);
    request(32'hA000_1234);
    expect_res("dmw0_plv0", 1'b1, 32'h0000_1234, 1'b0, 6'h00);

    csr_wr(14'h000, 32'h0000_0013);
    request(32'hA000_1234);
    expect_res("dmw0_plv3_off", 1'b0, 32'h0, 1'b0, 6'h3F);
    csr_wr(14'h180, 32'hA000_0019);
    request(32'hA000_1234);
    expect_res("dmw0_plv3_on", 1'b1, 32'h0000_1234, 1'b0, 6'h00);

    csr_wr(14'h181, 32'hA200_0009);
    request(32'hA000_1234);
    expect_res("both_dmw0_wins", 1'b1, 32'h0000_1234, 1'b0, 6'h00);
    csr_wr(14'h180, 32'h0000_0000);
    request(32'hA000_1234);
    expect_res("dmw1_only", 1'b1, 32'h2000_1234, 1'b1, 6'h00);
    csr_wr(14'h000, 32'h0000_0011);
    request(32'hA000_1234);
    expect_res("plv1_nomatch", 1'b0, 32'h0, 1'b0, 6'h3F);

    // LATENCY=3: a repeated req while busy is ignored, one finish at t+3.
    csr_wr(14'h000, 32'h0000_0013);
    f0 = fin_cnt[1];
    req = 1'b1; vaddr = 32'hA000_0100;
    step();
    check("lat3_t1_finish", if3.tlb_finish, 1'b0);
    step();
    req = 1'b0;
    check("lat3_t2_finish", if3.tlb_finish, 1'b0);
    step();
    check("lat3_t3_finish", if3.tlb_finish, 1'b1);
    repeat (4) step();
    check("lat3_one_finish", 32'(fin_cnt[1] - f0), 32'd1);
    expect_res("lat3_res", 1'b1, 32'h2000_0100, 1'b1, 6'h00);

    // Cancel in WAIT: no finish, idle the following cycle.
    f0 = fin_cnt[1];
    req = 1'b1; vaddr = 32'h1234_5678;
    step();
    req = 1'b0;
    step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cancel_busy_t3", if3.tlb_busy, 1'b0);
    repeat (3) step();
    check("cancel_no_finish", 32'(fin_cnt[1] - f0), 32'd0);

    // Same-cycle CRMD write does not affect the request being accepted.
    csr_wr(14'h000, 32'h0000_0008);
    req = 1'b1; vaddr = 32'h8000_0ABC;
    csr_wen = 1'b1; csr_waddr = 14'h000; csr_wdata = 32'h0;
    step();
    req = 1'b0; csr_wen = 1'b0;
    repeat (5) step();
    expect_res("snapshot_da", 1'b1, 32'h8000_0ABC, 1'b1, 6'h00);
    request(32'h8000_0ABC);
    expect_res("no_da_no_pg", 1'b0, 32'h0, 1'b0, 6'h3F);

    // Reset in the middle of a LATENCY=3 request.
    csr_wr(14'h000, 32'h0000_0013);
    f0 = fin_cnt[1];
    req = 1'b1; vaddr = 32'h0000_4444;
    step();
    req = 1'b0;
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    repeat (4) step();
    check("reset_mid_no_finish", 32'(fin_cnt[1] - f0), 32'd0);
    check("reset_mid_crmd", crmd_q3, 32'h0000_0008);
    expect_res("reset_mid_res", 1'b0, 32'h0, 1'b0, 6'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu7_dmw_tlb.md
Name: cpu7_dmw_tlb

Overview:
- Replaces the pass-through TLB stub on the cpu7 top.
- Services one translation port (instruction or data) between the cache and the core, and owns the translation CSRs: CRMD, DMW0 and DMW1.
- Translates in direct-address (DA) mode or through two direct-mapped windows.
- Returns the physical address, uncached attribute and exception code to the cache using the existing req/finish handshake.

Parameters:
- GRLEN, 32, virtual address and CSR data width.
- PABITS, 32, physical address width (must be ≤ GRLEN).
- CSR_BIT, 14, CSR address width.
- IS_DATA, 0, selects the port kind: 0 = instruction port (uses CRMD.DATF), 1 = data port (uses CRMD.DATM).
- LATENCY, 1, cycles from request accept to tlb_finish; legal range 1..4.

Ports:
- clk, input, 1, clock.
- resetn, input, 1, synchronous active-low reset.
- csr_wen, input, 1, CSR write strobe.
- csr_waddr, input, CSR_BIT, CSR write address.
- csr_wdata, input, GRLEN, CSR write data.
- tlb_req, input, 1, translation request from the cache.
- tlb_vaddr, input, GRLEN, virtual address to translate.
- tlb_cancel, input, 1, abort of the in-flight request.
- tlb_busy, output, 1, a request is in flight.
- tlb_finish, output, 1, one-cycle pulse: result valid.
- tlb_hit, output, 1, translation succeeded.
- tlb_paddr, output, PABITS, physical address.
- tlb_uncache, output, 1, access is uncached.
- tlb_exccode, output, 6, exception code; 0 when tlb_hit=1.
- crmd_q, output, GRLEN, current CRMD value (for the CSR read mux).

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low on resetn; sampled only at the clk rising edge.

CSRs (GRLEN-wide, unused bits read 0):
- CRMD at 0x000: PLV[1:0], IE[2], DA[3], PG[4], DATF[6:5], DATM[8:7]. Reset value 0x0000_0008 (DA=1, all else 0).
- DMW0 at 0x180 and DMW1 at 0x181: PLV0[0], PLV3[3], MAT[5:4], PSEG[27:25], VSEG[31:29]. Reset value 0.
- A write takes effect in the cycle after csr_wen.
- Writes to other addresses are ignored.

FSM:
- IDLE: tlb_busy=0. tlb_req=1 accepts the request and captures tlb_vaddr plus a snapshot of CRMD/DMW0/DMW1 as they stand before any same-cycle CSR write. Counter is loaded with LATENCY-1. Next state is WAIT if LATENCY>1, else RESP.
- WAIT: counter decrements each cycle; moves to RESP when the counter reaches 0.
- RESP: tlb_finish=1 for exactly one cycle with the result; returns to IDLE.
- A new request may be accepted in the cycle after RESP (earliest: IDLE).
- tlb_req while busy: ignored. No state change, no second finish.
- tlb_cancel while in WAIT or RESP: go to IDLE in the next cycle. tlb_finish is forced to 0 in the cancel cycle. Result outputs are unchanged.
- tlb_cancel in IDLE has no effect.
- tlb_busy=1 in WAIT and RESP.

Translation (from the snapshot; combinational at accept, registered):
- DA=1: paddr = vaddr[PABITS-1:0], hit=1, uncache = (IS_DATA ? DATM : DATF) == 0.
- Otherwise, with PG=1, a DMW matches when VSEG == vaddr[31:29] and its PLV enable bit is set for the current PLV:
  - PLV=0 needs PLV0.
  - PLV=3 needs PLV3.
  - PLV 1 or 2 never matches.
- If both DMWs match, DMW0 wins.
- On a match: paddr = {PSEG, vaddr[28:0]} truncated to PABITS, hit=1, uncache = (MAT==0).
- No match, or DA=0 with PG=0: hit=0, paddr=0, uncache=0, exccode=6'h3F (TLBR).

Outputs:
- tlb_hit, tlb_paddr, tlb_uncache and tlb_exccode hold their last result until the next RESP.
- On reset all of them are 0, as are tlb_finish and tlb_busy.
- Reset mid-request: FSM goes to IDLE, no finish is generated, CSRs return to their reset values.
- Latency from accept to finish is exactly LATENCY cycles.

Test Plan:
- After reset, LATENCY=1, req vaddr=0x1C00_0040 -> finish in the next cycle, hit=1, paddr=0x1C00_0040, uncache=1 (DATF=0), exccode=0.
- Write CRMD=0x10 (PG=1, PLV=0) and DMW0=0xA000_0011 (VSEG=5, PSEG=0, MAT=1, PLV0=1), then req 0xA000_1234 -> hit=1, paddr=0x0000_1234, uncache=0.
- Same setup with CRMD.PLV=3 -> hit=0, paddr=0, exccode=0x3F. Then also set DMW0.PLV3 -> hit=1.
- DMW0 and DMW1 both matching VSEG=5, DMW1.PSEG=1 -> paddr takes PSEG from DMW0 (0x0000_1234).
- LATENCY=3: req at cycle t -> finish only at t+3. Second req at t+1 is ignored (exactly one finish). tlb_cancel at t+2 -> no finish, busy=0 at t+3.
- req together with a CRMD write that sets DA=0/PG=0 in the same cycle -> DA translation (hit=1); the following req -> exccode 0x3F.
